// File: rtl/conv_8b_32b.sv
// Receive-side deserializer: rebuilds 32-bit words from a valid-qualified byte
// stream on the byte-rate clock, flagging words that are abandoned mid-way.
module conv_8b_32b #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        err_out,
  output logic [1:0]  byte_cnt
);

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic        validOut_q, validOut_d;
  logic        errOut_q, errOut_d;
  logic [31:0] shiftNext;

  // Shifting in the new byte means the fourth byte lands directly in the right
  // lane, so the completed word can be loaded on the same edge as byte 3.
  assign shiftNext = MSB_FIRST ? {shift_q[23:0], data_in}
                               : {data_in, shift_q[31:8]};

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byteCnt_q  <= 2'd0;
      shift_q    <= 32'h0;
      data_q     <= 32'h0;
      validOut_q <= 1'b0;
      errOut_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      validOut_q <= validOut_d;
      errOut_q   <= errOut_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    validOut_d = 1'b0;
    errOut_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          shift_d   = shiftNext;
          byteCnt_d = 2'd1;
          state_d   = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (valid_in) begin
          shift_d = shiftNext;
          if (byteCnt_q == 2'd3) begin
            data_d     = shiftNext;
            validOut_d = 1'b1;
            byteCnt_d  = 2'd0;
            state_d    = IDLE;
          end else begin
            byteCnt_d = byteCnt_q + 2'd1;
          end
        end else begin
          // A gap inside a word means the link lost framing; drop the partial word.
          errOut_d  = 1'b1;
          byteCnt_d = 2'd0;
          state_d   = IDLE;
        end
      end
      default: begin
        byteCnt_d = 2'd0;
        state_d   = IDLE;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = validOut_q;
  assign err_out   = errOut_q;
  assign byte_cnt  = byteCnt_q;

endmodule

// File: tb/tb_conv_8b_32b.sv
// Directed bench for conv_8b_32b: both byte orders are instantiated side by side
// and every scenario checks its own hand-computed expected values.
module tb_conv_8b_32b;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  dataIn;
  logic        validIn;
  logic [31:0] dataOut, dataOutLsb;
  logic        validOut, validOutLsb;
  logic        errOut, errOutLsb;
  logic [1:0]  byteCnt, byteCntLsb;

  int checks;
  int errors;

  conv_8b_32b #(.MSB_FIRST(1'b1)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(dataIn), .valid_in(validIn),
    .data_out(dataOut), .valid_out(validOut), .err_out(errOut), .byte_cnt(byteCnt)
  );

  conv_8b_32b #(.MSB_FIRST(1'b0)) dutLsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(dataIn), .valid_in(validIn),
    .data_out(dataOutLsb), .valid_out(validOutLsb), .err_out(errOutLsb),
    .byte_cnt(byteCntLsb)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Drive on the falling edge, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] b);
    @(negedge clk_4f);
    validIn = v;
    dataIn  = b;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; validIn = 1'b0; dataIn = 8'h00;
    repeat (2) @(posedge clk_4f);
    #1;
    checks += 4;
    if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_data actual=%h expected=%h", dataOut, 32'h0); end
    if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", validOut); end
    if (errOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_err actual=%b expected=0", errOut); end
    if (byteCnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt actual=%0d expected=0", byteCnt); end
    @(negedge clk_4f);
    reset = 1'b0;
  endtask

  task automatic test_single_word;
    logic [7:0] bytes [4] = '{8'hFF, 8'hFB, 8'hBF, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bytes[i]);
      checks += 2;
      if (validOut !== (i == 3)) begin errors++; $display("[TB] FAIL single_valid[%0d] actual=%b expected=%b", i, validOut, (i == 3)); end
      if (byteCnt !== 2'((i + 1) % 4)) begin errors++; $display("[TB] FAIL single_cnt[%0d] actual=%0d expected=%0d", i, byteCnt, (i + 1) % 4); end
    end
    checks += 2;
    if (dataOut !== 32'hFFFBBFFF) begin errors++; $display("[TB] FAIL single_data actual=%h expected=FFFBBFFF", dataOut); end
    if (errOut !== 1'b0) begin errors++; $display("[TB] FAIL single_err actual=%b expected=0", errOut); end
    applyStimulus(1'b0, 8'h00);
    checks += 2;
    if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width actual=%b expected=0", validOut); end
    if (dataOut !== 32'hFFFBBFFF) begin errors++; $display("[TB] FAIL single_hold actual=%h expected=FFFBBFFF", dataOut); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [8] = '{8'hDD, 8'hDD, 8'hDD, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h03};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, bytes[i]);
      checks++;
      if (validOut !== (i == 3 || i == 7)) begin errors++; $display("[TB] FAIL b2b_valid[%0d] actual=%b expected=%b", i, validOut, (i == 3 || i == 7)); end
      if (i == 3) begin
        checks++;
        if (dataOut !== 32'hDDDDDDDD) begin errors++; $display("[TB] FAIL b2b_word0 actual=%h expected=DDDDDDDD", dataOut); end
      end
      if (i == 5) begin
        checks++;
        if (dataOut !== 32'hDDDDDDDD) begin errors++; $display("[TB] FAIL b2b_partial_leak actual=%h expected=DDDDDDDD", dataOut); end
      end
    end
    checks++;
    if (dataOut !== 32'h00000003) begin errors++; $display("[TB] FAIL b2b_word1 actual=%h expected=00000003", dataOut); end
  endtask

  task automatic test_abort;
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFB);
    applyStimulus(1'b0, 8'h00);
    checks += 4;
    if (errOut !== 1'b1) begin errors++; $display("[TB] FAIL abort_err actual=%b expected=1", errOut); end
    if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid actual=%b expected=0", validOut); end
    if (dataOut !== 32'h00000003) begin errors++; $display("[TB] FAIL abort_data actual=%h expected=00000003", dataOut); end
    if (byteCnt !== 2'd0) begin errors++; $display("[TB] FAIL abort_cnt actual=%0d expected=0", byteCnt); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hAA);
      checks += 2;
      if (errOut !== 1'b0) begin errors++; $display("[TB] FAIL abort_err_clear[%0d] actual=%b expected=0", i, errOut); end
      if (validOut !== (i == 3)) begin errors++; $display("[TB] FAIL abort_recover_valid[%0d] actual=%b expected=%b", i, validOut, (i == 3)); end
    end
    checks++;
    if (dataOut !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL abort_recover_data actual=%h expected=AAAAAAAA", dataOut); end
  endtask

  task automatic test_async_reset;
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(1'b1, 8'hDD);
    applyStimulus(1'b1, 8'h00);
    #1;
    reset   = 1'b1;
    validIn = 1'b0;
    #1;
    checks += 4;
    if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL areset_data actual=%h expected=00000000", dataOut); end
    if (validOut !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid actual=%b expected=0", validOut); end
    if (byteCnt !== 2'd0) begin errors++; $display("[TB] FAIL areset_cnt actual=%0d expected=0", byteCnt); end
    if (errOut !== 1'b0) begin errors++; $display("[TB] FAIL areset_err actual=%b expected=0", errOut); end
    @(negedge clk_4f);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, bytes[i]);
      checks++;
      if (errOut !== 1'b0) begin errors++; $display("[TB] FAIL areset_no_err[%0d] actual=%b expected=0", i, errOut); end
    end
    checks += 2;
    if (validOut !== 1'b1) begin errors++; $display("[TB] FAIL areset_word_valid actual=%b expected=1", validOut); end
    if (dataOut !== 32'h12345678) begin errors++; $display("[TB] FAIL areset_word actual=%h expected=12345678", dataOut); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] bytes [4] = '{8'h03, 8'h00, 8'h00, 8'hDD};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, bytes[i]);
    checks += 3;
    if (validOutLsb !== 1'b1) begin errors++; $display("[TB] FAIL lsb_valid actual=%b expected=1", validOutLsb); end
    if (dataOutLsb !== 32'hDD000003) begin errors++; $display("[TB] FAIL lsb_data actual=%h expected=DD000003", dataOutLsb); end
    if (dataOut !== 32'h030000DD) begin errors++; $display("[TB] FAIL msb_data actual=%h expected=030000DD", dataOut); end
  endtask

  task automatic test_idle_hold;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h5A);
      if (validOut || errOut || validOutLsb || errOutLsb) pulses++;
    end
    checks += 3;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL idle_pulses actual=%0d expected=0", pulses); end
    if (dataOut !== 32'h030000DD) begin errors++; $display("[TB] FAIL idle_hold actual=%h expected=030000DD", dataOut); end
    if (dataOutLsb !== 32'hDD000003) begin errors++; $display("[TB] FAIL idle_hold_lsb actual=%h expected=DD000003", dataOutLsb); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_lsb_first();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
